// File: rtl/fib_seq_ctrl_if.sv
// Bundle between fib_seq_ctrl and its surroundings: the start/done control
// pair from the top level, the register file ports and the ALU ports.
//
// Handshake: start is only looked at while busy is low. When it is seen, the
// request is taken on that rising edge (seeds and len are latched there) and
// busy rises. done pulses for exactly one cycle at the end of the run; err and
// wr_cnt are meaningful while done is high. start is ignored while busy.
interface fib_seq_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] seed0;
  logic [DATA_W-1:0] seed1;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        dbg_state;

  // Sequencer side.
  modport slave (
    input  start, seed0, seed1, len, rf_rdata, alu_out,
    output busy, done, err, wr_cnt, rf_raddr, rf_waddr, rf_wdata, rf_we,
           alu_a, alu_b, alu_op, dbg_state
  );

  // Top-level control / register file / ALU side.
  modport master (
    output start, seed0, seed1, len, rf_rdata, alu_out,
    input  busy, done, err, wr_cnt, rf_raddr, rf_waddr, rf_wdata, rf_we,
           alu_a, alu_b, alu_op, dbg_state
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: fills a window of the register file with f(0)=seed0,
// f(1)=seed1, f(k)=f(k-1)+f(k-2), one write per cycle, starting at BASE_ADDR.
// Optional macro FIB_OVF_STOP_EN: stop the run with err on signed overflow
// instead of writing the wrapped sum.
module fib_seq_ctrl #(
  parameter int         ADDR_W    = 6,
  parameter int         DATA_W    = 32,
  parameter logic [4:0] OP_ADD    = 5'h01,
  parameter int         BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  fib_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED0 = 3'd1,
    SEED1 = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W:0]   k;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] s0_q;
  logic [DATA_W-1:0] s1_q;
  logic [DATA_W-1:0] prev;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   wr_cnt_q;

  logic [ADDR_W-1:0] raddr_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              we_c;
  logic [DATA_W-1:0] alu_a_c;
  logic [DATA_W-1:0] alu_b_c;
  logic              ovf_c;
  logic [ADDR_W-1:0] k_lo;

  // Addresses wrap modulo the file depth by truncation to ADDR_W bits.
  assign k_lo = k[ADDR_W-1:0];

  // Register file and ALU drive, decoded from state, k and prev; all zero in IDLE.
  always_comb begin
    raddr_c = '0;
    waddr_c = '0;
    wdata_c = '0;
    we_c    = 1'b0;
    alu_a_c = '0;
    alu_b_c = '0;
    ovf_c   = 1'b0;
    case (state)
      SEED0: begin
        we_c    = 1'b1;
        waddr_c = BASE;
        wdata_c = s0_q;
      end
      SEED1: begin
        we_c    = 1'b1;
        waddr_c = BASE + A_ONE;
        wdata_c = s1_q;
        // seed0 was committed on the previous edge, so it reads back here.
        raddr_c = BASE;
      end
      CALC: begin
        raddr_c = BASE + k_lo - A_ONE;
        alu_a_c = prev;
        alu_b_c = bus.rf_rdata;
        waddr_c = BASE + k_lo;
        wdata_c = bus.alu_out;
`ifdef FIB_OVF_STOP_EN
        ovf_c = (prev[DATA_W-1] == bus.rf_rdata[DATA_W-1]) &&
                (bus.alu_out[DATA_W-1] != prev[DATA_W-1]);
`else
        ovf_c = 1'b0;
`endif
        we_c = !ovf_c;
      end
      default: ;
    endcase
  end

  assign bus.rf_raddr  = raddr_c;
  assign bus.rf_waddr  = waddr_c;
  assign bus.rf_wdata  = wdata_c;
  assign bus.rf_we     = we_c;
  assign bus.alu_a     = alu_a_c;
  assign bus.alu_b     = alu_b_c;
  assign bus.alu_op    = OP_ADD;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_cnt    = wr_cnt_q;
  assign bus.dbg_state = state;

  // Sequencer FSM with registered busy/done/err/wr_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      len_q    <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      prev     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (we_c) begin
        wr_cnt_q <= wr_cnt_q + CNT_ONE;
      end
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            wr_cnt_q <= '0;
            busy_q   <= 1'b1;
            if (bus.len >= LEN_MIN && bus.len <= LEN_MAX) begin
              s0_q  <= bus.seed0;
              s1_q  <= bus.seed1;
              len_q <= bus.len;
              err_q <= 1'b0;
              state <= SEED0;
            end else begin
              // Illegal length: report immediately, touch nothing.
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        SEED0: begin
          state <= SEED1;
        end
        SEED1: begin
          prev <= bus.rf_rdata;
          k    <= (ADDR_W+1)'(2);
          if (len_q > LEN_MIN) begin
            state <= CALC;
          end else begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        CALC: begin
          if (ovf_c) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            prev <= bus.rf_rdata;
            k    <= k + CNT_ONE;
            if (k == len_q - CNT_ONE) begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencer that fills a contiguous window of the 64x32 register file with an additive recurrence: f(0)=seed0, f(1)=seed1, f(k)=f(k-1)+f(k-2).
- Drives the register file's single read port and single write port, and the ALU operands and opcode.
- Replaces hand-coded init/loop counters in the top level with a start/done-handshaked FSM.
- Sits between the top-level control and the register file / ALU pair.

Parameters:
- ADDR_W, 6, register file address width (depth 2^ADDR_W).
- DATA_W, 32, data width.
- OP_ADD, 5'h01, ALU opcode for signed add, driven on alu_op.
- BASE_ADDR, 0, register index of f(0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- seed0  in  DATA_W  f(0); latched on an accepted start.
- seed1  in  DATA_W  f(1); latched on an accepted start.
- len  in  ADDR_W+1  number of entries to write; legal range 2..2^ADDR_W; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid while done is high.
- wr_cnt  out  ADDR_W+1  entries written by the last run; held until the next accepted start.
- rf_raddr  out  ADDR_W  register file read address.
- rf_rdata  in  DATA_W  register file read data; combinational from rf_raddr.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- rf_we  out  1  register file write enable; the write commits at the rising edge.
- alu_a  out  DATA_W  ALU operand a.
- alu_b  out  DATA_W  ALU operand b.
- alu_op  out  5  constant OP_ADD.
- alu_out  in  DATA_W  ALU result; combinational.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, and the following are all 0: busy, done, err, wr_cnt, rf_we, rf_waddr, rf_wdata, rf_raddr, alu_a, alu_b. alu_op is always OP_ADD.
- All rf_*/alu_* outputs are combinational decodes of state, index k, and the internal register prev. In IDLE they are 0.
- Addresses are computed as BASE_ADDR+k, truncated to ADDR_W, so they wrap modulo 2^ADDR_W.

States:
- IDLE:
  - start=1 with len in 2..2^ADDR_W: latch seed0/seed1/len, clear wr_cnt, go to SEED0.
  - start=1 with any other len: go to DONE with err set and no writes.
- SEED0: rf_we=1, rf_waddr=BASE, rf_wdata=seed0. Go to SEED1.
- SEED1:
  - Write: rf_we=1, rf_waddr=BASE+1, rf_wdata=seed1.
  - Read: rf_raddr=BASE, which reads back seed0 committed at the previous edge; prev<=rf_rdata.
  - k<=2. Go to CALC if len>2, else go to DONE.
- CALC (one cycle per k):
  - rf_raddr=BASE+k-1; alu_a=prev (f(k-2)); alu_b=rf_rdata (f(k-1)).
  - rf_we=1; rf_waddr=BASE+k; rf_wdata=alu_out.
  - prev<=rf_rdata; k<=k+1.
  - When k==len-1, go to DONE after this write.
- DONE: done=1, busy=1, err per cause. Go to IDLE.

Counting and timing:
- wr_cnt increments on every cycle where rf_we=1.
- Arithmetic is two's complement, DATA_W bits; overflow wraps.
- Latency: done is high in the (len+1)th cycle after the start-accept edge. Total writes = len, one per cycle, with no gaps.

Boundaries:
- start while busy: ignored; no effect on the current run.
- rst mid-run: at the next edge the FSM is in IDLE with rf_we=0. Entries already written remain in the register file.
- len=2^ADDR_W: the window covers the whole file once; no address is written twice.
- BASE_ADDR near the top of the file: writes wrap to index 0 onward.

Optional Feature:
- Macro FIB_OVF_STOP_EN.
- Defined:
  - In CALC, signed overflow is detected when alu_a and alu_b have the same sign and alu_out's sign differs.
  - On overflow, that cycle's rf_we is forced to 0, the FSM goes to DONE with err=1, and wr_cnt stops at the count of good entries.
- Not defined:
  - No overflow detection; results wrap.
  - err is set only for an illegal len.

Test Plan:
1. seed0=2, seed1=2, len=64, BASE=0 -> reg[0..5]=2,2,4,6,10,16; exactly 64 rf_we cycles; done in cycle 65 after start; err=0; wr_cnt=64.
2. seed0=0, seed1=1, len=10 -> reg[9]=34, reg[10] untouched; done high for exactly 1 cycle; busy low the following cycle.
3. len=1, then len=0, then len=65 -> no rf_we; done=1 with err=1 one cycle after each start; wr_cnt=0.
4. start pulsed during CALC -> ignored; rst asserted at k=5 -> rf_we=0 and busy=0 after the edge; a new start then runs cleanly.
5. BASE_ADDR=60, seed0=0, seed1=1, len=8 -> writes to addresses 60,61,62,63,0,1,2,3 with values 0,1,1,2,3,5,8,13.
6. seed0=seed1=0x40000000, len=8 -> with FIB_OVF_STOP_EN: no write to index 2, err=1, wr_cnt=2. Without it: reg[2]=0x80000000 and the run completes with wr_cnt=8.
